// File: rtl/otter_int_pkg.sv
// Shared types and defaults for the OTTER interrupt controller.
package otter_int_pkg;

    localparam int NUM_SRC_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TAKE    = 2'd1,
        ST_HANDLER = 2'd2,
        ST_RETURN  = 2'd3
    } int_state_e;

endpackage

// File: rtl/otter_irq_sync.sv
// Two-flop synchronizer plus rising-edge detector for one interrupt line.
module otter_irq_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_irq,
    output logic o_rise
);

    logic       r_s1;
    logic       r_s2;
    logic       r_s3;
    logic [2:0] r_warm;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_s3   <= 1'b0;
            r_warm <= '0;
        end else begin
            r_s1   <= i_irq;
            r_s2   <= r_s1;
            r_s3   <= r_s2;
            r_warm <= {r_warm[1:0], 1'b1};
        end
    end

    // Edges are ignored until the pipeline has refilled after reset,
    // so a line held high through reset does not look like a new edge.
    assign o_rise = r_warm[2] & r_s2 & ~r_s3;

endmodule

// File: rtl/otter_int_ctrl.sv
// Interrupt controller: pending capture, priority pick and take/return FSM.
module otter_int_ctrl
    import otter_int_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int CW      = $clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic [NUM_SRC-1:0] irq_mask,
    input  logic               mie,
    input  logic               mstatus,
    input  logic               commit,
    input  logic               mret,
    output logic               int_taken,
    output logic               int_ret,
    output logic [CW-1:0]      int_cause,
    output logic [NUM_SRC-1:0] pending,
    output logic               in_handler
);

    int_state_e         r_state;
    int_state_e         w_next;
    logic [NUM_SRC-1:0] r_pending;
    logic [CW-1:0]      r_cause;
    logic               r_taken;
    logic               r_ret;

    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] w_cand;
    logic [NUM_SRC-1:0] w_clr;
    logic [CW-1:0]      w_win;
    logic               w_elig;
    logic               w_take;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
        otter_irq_sync u_sync (
            .clk    (clk),
            .rst    (rst),
            .i_irq  (irq_in[g]),
            .o_rise (w_rise[g])
        );
    end

    assign w_cand = r_pending & irq_mask;
    assign w_elig = (|w_cand) & mie & mstatus;
    assign w_take = (r_state == ST_IDLE) & w_elig & commit;

    // Descending scan leaves the lowest-index candidate as winner.
    always_comb begin
        w_win = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_cand[i]) w_win = CW'(i);
        end
    end

    always_comb begin
        w_clr = '0;
        if (w_take) w_clr = NUM_SRC'(1) << w_win;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:    if (w_take) w_next = ST_TAKE;
            ST_TAKE:    w_next = ST_HANDLER;
            ST_HANDLER: if (commit && mret) w_next = ST_RETURN;
            ST_RETURN:  w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pending <= '0;
            r_cause   <= '0;
            r_taken   <= 1'b0;
            r_ret     <= 1'b0;
        end else begin
            r_state   <= w_next;
            // A fresh edge on the source being cleared keeps it pending.
            r_pending <= (r_pending & ~w_clr) | w_rise;
            if (w_take) r_cause <= w_win;
            r_taken   <= (r_state == ST_TAKE);
            r_ret     <= (r_state == ST_RETURN);
        end
    end

    assign int_taken  = r_taken;
    assign int_ret    = r_ret;
    assign int_cause  = r_cause;
    assign pending    = r_pending;
    assign in_handler = (r_state == ST_TAKE) || (r_state == ST_HANDLER);

endmodule
